// File: rtl/key_xor_pipe.sv
// key_xor_pipe: round-key XOR stage with writable key bank and 1-cycle output register.
// Optional KEY_XOR_AUTO_ROUND_EN: round index from an internal auto-advancing counter.
module key_xor_pipe #(
   parameter int DATA_W   = 128,
   parameter int NUM_KEYS = 10,
   parameter int IDX_W    = $clog2(NUM_KEYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_we_i,
   input  logic [IDX_W-1:0]  key_addr_i,
   input  logic [DATA_W-1:0] key_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [IDX_W-1:0]  in_round_i,
   input  logic              in_sop_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [IDX_W-1:0]  out_round_o,
   output logic              out_err_o
);

   logic [DATA_W-1:0] keys_q [NUM_KEYS];
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [IDX_W-1:0]  round_q;
   logic              err_q;

   logic              accept;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] key_sel;
   logic              idx_err;
   logic              unused_in;

   assign in_ready_o = !valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

`ifdef KEY_XOR_AUTO_ROUND_EN
   logic [IDX_W-1:0] cnt_q;
   logic [IDX_W-1:0] cnt_d;

   assign unused_in = ^in_round_i;

   // Index restarts at 0 on start-of-packet, else follows the counter.
   always_comb begin
      idx   = in_sop_i ? '0 : cnt_q;
      cnt_d = cnt_q;
      if (accept) begin
         if (int'(idx) == NUM_KEYS - 1) cnt_d = '0;
         else                           cnt_d = idx + IDX_W'(1);
      end
   end

   // Round counter advances only on accepted blocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   assign unused_in = in_sop_i;
   assign idx       = in_round_i;
`endif

   // Key lookup; an out-of-range index selects zero and flags an error.
   always_comb begin
      key_sel = '0;
      idx_err = (int'(idx) >= NUM_KEYS);
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (idx == IDX_W'(k)) key_sel = keys_q[k];
      end
   end

   // Key bank writes; out-of-range addresses match no entry and are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_KEYS; k++) keys_q[k] <= '0;
      end else if (key_we_i) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_addr_i == IDX_W'(k)) keys_q[k] <= key_data_i;
         end
      end
   end

   // Output register: load on accept, drop valid once consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         round_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         data_q  <= in_data_i ^ key_sel;
         round_q <= idx;
         err_q   <= idx_err;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_round_o = round_q;
   assign out_err_o   = err_q;

endmodule

// File: tb/tb_key_xor_pipe.sv
// tb_key_xor_pipe: scoreboard bench for key_xor_pipe.
// Reference keeps a key array, an occupancy flag and a round counter.
module tb_key_xor_pipe;

   localparam int DW = 128;
   localparam int NK = 10;
   localparam int IW = 4;

   typedef struct {
      logic [DW-1:0] d;
      logic [IW-1:0] r;
      logic          e;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_we_i = 1'b0;
   logic [IW-1:0] key_addr_i = '0;
   logic [DW-1:0] key_data_i = '0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i = '0;
   logic [IW-1:0] in_round_i = '0;
   logic          in_sop_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [DW-1:0] out_data_o;
   logic [IW-1:0] out_round_o;
   logic          out_err_o;

   int total = 0;
   int bad   = 0;

   exp_t          q[$];
   logic [DW-1:0] key_m [NK];
   bit            ov_m = 0;
   int            cnt_m = 0;

   always #5 clk = ~clk;

   key_xor_pipe dut (
      .clk(clk), .rst(rst),
      .key_we_i(key_we_i), .key_addr_i(key_addr_i), .key_data_i(key_data_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_round_i(in_round_i), .in_sop_i(in_sop_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_round_o(out_round_o), .out_err_o(out_err_o)
   );

   task automatic check(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock of stimulus; the expected result is queued on acceptance.
   task automatic step(input bit we, input int addr, input logic [DW-1:0] kd,
                       input bit v, input logic [DW-1:0] d, input int r,
                       input bit sop, input bit ordy, output bit acc);
      int idx;
      exp_t e;
      key_we_i    = we;
      key_addr_i  = IW'(addr);
      key_data_i  = kd;
      in_valid_i  = v;
      in_data_i   = d;
      in_round_i  = IW'(r);
      in_sop_i    = sop;
      out_ready_i = ordy;
      @(negedge clk);
      check("in_ready", DW'(in_ready_o), DW'(!ov_m || ordy));
      acc = v && (!ov_m || ordy);
      if (acc) begin
`ifdef KEY_XOR_AUTO_ROUND_EN
         idx   = sop ? 0 : cnt_m;
         cnt_m = (idx + 1) % NK;
`else
         idx = r;
`endif
         e.d = (idx < NK) ? (d ^ key_m[idx]) : d;
         e.r = IW'(idx);
         e.e = (idx >= NK);
         q.push_back(e);
      end
      @(posedge clk);
      if (we && addr < NK) key_m[addr] = kd;
      ov_m = acc ? 1'b1 : (ordy ? 1'b0 : ov_m);
      #1;
      key_we_i   = 1'b0;
      in_valid_i = 1'b0;
   endtask

   // Monitor: pop on every handshake, and check holds stay stable.
   logic          pv = 1'b0, pr = 1'b0, pe = 1'b0;
   logic [DW-1:0] pd = '0;
   logic [IW-1:0] prd = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            check("hold_valid", DW'(out_valid_o), DW'(1));
            check("hold_data", out_data_o, pd);
            check("hold_round", DW'(out_round_o), DW'(prd));
            check("hold_err", DW'(out_err_o), DW'(pe));
         end
         if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_out actual=%h required=none", out_data_o);
            end else begin
               e = q.pop_front();
               check("out_data", out_data_o, e.d);
               check("out_round", DW'(out_round_o), DW'(e.r));
               check("out_err", DW'(out_err_o), DW'(e.e));
            end
         end
         pv  = out_valid_o;
         pr  = out_ready_i;
         pd  = out_data_o;
         prd = out_round_o;
         pe  = out_err_o;
      end
   end

   task automatic drain();
      bit a;
      for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, 0, 0, 1, a);
      check("queue_empty", DW'(q.size()), DW'(0));
   endtask

   task automatic reset_model();
      for (int k = 0; k < NK; k++) key_m[k] = '0;
      ov_m  = 0;
      cnt_m = 0;
      q.delete();
   endtask

   initial begin
      bit a;
      logic [DW-1:0] k0, k1, held;
      k0 = 128'hC7DB5C958C8807843A94F27C81B18E7A;
      k1 = 128'h7E09FCD1B3315D0597CAB1BE78E69B9B;
      reset_model();
      #2;
      check("rst_valid", DW'(out_valid_o), DW'(0));
      check("rst_data", out_data_o, '0);
      check("rst_round", DW'(out_round_o), DW'(0));
      check("rst_err", DW'(out_err_o), DW'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      check("ready_after_rst", DW'(in_ready_o), DW'(1));

      // Cleared keys pass data through.
      held = rnd128();
      step(0, 0, '0, 1, held, 3, 1, 1, a);
      drain();

      // Directed key vectors.
      step(1, 0, k0, 0, '0, 0, 0, 1, a);
      step(1, 1, k1, 0, '0, 0, 0, 1, a);
      step(0, 0, '0, 1, '0, 0, 1, 1, a);
      step(0, 0, '0, 1, {DW{1'b1}}, 1, 0, 1, a);
      drain();

      // Backpressure: one held result, then a blocked offer.
      held = rnd128();
      step(0, 0, '0, 1, rnd128(), 5, 1, 0, a);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, '0, 1, held, 6, 0, 0, a);
         check("bp_blocked", DW'(a), DW'(0));
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 0, '0, 1, (i == 0) ? held : rnd128(), i, i == 0, 1, a);
         check("b2b_accept", DW'(a), DW'(1));
      end
      drain();

      // Write/accept collision on round 2.
      step(1, 2, rnd128(), 0, '0, 0, 0, 1, a);
      step(1, 2, DW'(1), 1, '0, 2, 1, 1, a);
      step(0, 0, '0, 1, '0, 2, 1, 1, a);
      drain();

      // Out-of-range round and dropped write.
      step(0, 0, '0, 1, rnd128(), 12, 1, 1, a);
      step(1, 11, rnd128(), 0, '0, 0, 0, 1, a);
      for (int i = 0; i < NK; i++) step(0, 0, '0, 1, rnd128(), i, i == 0, 1, a);
      drain();

      // Auto round: sop on accepts 1 and 14.
      for (int i = 0; i < 23; i++) step(0, 0, '0, 1, rnd128(), i % NK, i == 0 || i == 13, 1, a);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 15), rnd128(),
              $urandom_range(0, 3) != 0, rnd128(), $urandom_range(0, 12),
              $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, a);
      end
      drain();

      // Asynchronous reset while a result is held.
      step(1, 4, rnd128(), 1, rnd128(), 4, 1, 0, a);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("arst_valid", DW'(out_valid_o), DW'(0));
      check("arst_data", out_data_o, '0);
      check("arst_round", DW'(out_round_o), DW'(0));
      check("arst_err", DW'(out_err_o), DW'(0));
      reset_model();
      @(posedge clk); #1;
      rst = 1'b1;
      check("arst_ready", DW'(in_ready_o), DW'(1));
      step(0, 0, '0, 1, rnd128(), 4, 1, 1, a);
      step(0, 0, '0, 1, rnd128(), 1, 0, 1, a);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
